// File: rtl/sample_bus_arbiter.sv
// sample_bus_arbiter: shares one 8-bit channel among masters A, B and C.
// It arbitrates in fixed-priority (A > B > C) or round-robin mode.
// Each tenure is bounded by a hold timer, and a turnaround gap of
// TURN_CYCLES idle cycles separates consecutive tenures on the shared bus.
module sample_bus_arbiter #(
    parameter int unsigned MAX_HOLD    = 16,  // 1..255, 0 disables the timeout
    parameter int unsigned TURN_CYCLES = 1    // 1..7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [7:0] data_a,
    input  logic [7:0] data_b,
    input  logic [7:0] data_c,
    input  logic       mode_rr,
    output logic [2:0] gnt,
    output logic       busy,
    output logic [7:0] sel_data,
    output logic       sel_valid,
    output logic       timeout
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    localparam bit         HOLD_EN   = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST = HOLD_EN ? 8'(MAX_HOLD - 1) : 8'd0;
    localparam logic [2:0] TURN_LAST = 3'(TURN_CYCLES - 1);

    state_e     state_q, state_d;
    logic [2:0] gnt_q, gnt_d;
    logic       busy_q, busy_d;
    logic [7:0] sel_data_q, sel_data_d;
    logic       sel_valid_q, sel_valid_d;
    logic       timeout_q, timeout_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic [2:0] turn_cnt_q, turn_cnt_d;
    logic [2:0] winner;

    // The fixed-priority pick mirrors the datapath's if/else-if select chain: A, then B, then C.
    function automatic logic [2:0] pick_fixed(input logic [2:0] r);
        logic [2:0] w;
        w = 3'b000;
        if (r[0]) begin
            w = 3'b001;
        end else if (r[1]) begin
            w = 3'b010;
        end else if (r[2]) begin
            w = 3'b100;
        end
        return w;
    endfunction

    // The round-robin pick starts at ptr and walks upward modulo 3. The first set request wins.
    function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [1:0] ptr);
        logic [2:0] w;
        int         idx;
        w = 3'b000;
        for (int k = 0; k < 3; k++) begin
            idx = (int'(ptr) + k) % 3;
            if (w == 3'b000 && r[idx]) begin
                w[idx] = 1'b1;
            end
        end
        return w;
    endfunction

    // The pointer moves to the master just after the one that held the bus.
    function automatic logic [1:0] next_ptr(input logic [2:0] g);
        logic [1:0] p;
        unique case (g)
            3'b001:  p = 2'd1;
            3'b010:  p = 2'd2;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Arbitration result, used only at the arbitration points (IDLE and the last TURN cycle).
    always_comb begin
        winner = mode_rr ? pick_rr(req, rr_ptr_q) : pick_fixed(req);
    end

    // Next-state and output logic for the IDLE / GRANT / TURN sequencer.
    always_comb begin
        // NOTE: every signal gets a default before the case statement, so no path can leave one unassigned and infer a latch.
        state_d     = state_q;
        gnt_d       = gnt_q;
        hold_cnt_d  = hold_cnt_q;
        turn_cnt_d  = turn_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        sel_data_d  = sel_data_q;
        sel_valid_d = 1'b0;
        timeout_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (winner != 3'b000) begin
                    state_d    = ST_GRANT;
                    gnt_d      = winner;
                    hold_cnt_d = 8'd0;
                end
            end

            ST_GRANT: begin
                // Capture the granted master's payload. It appears on sel_data one cycle behind gnt.
                sel_valid_d = 1'b1;
                unique case (gnt_q)
                    3'b001:  sel_data_d = data_a;
                    3'b010:  sel_data_d = data_b;
                    3'b100:  sel_data_d = data_c;
                    default: sel_data_d = sel_data_q;
                endcase

                if ((req & gnt_q) == 3'b000) begin
                    // A normal release takes precedence over a coincident hold expiry.
                    state_d    = ST_TURN;
                    gnt_d      = 3'b000;
                    hold_cnt_d = 8'd0;
                    turn_cnt_d = 3'd0;
                    rr_ptr_d   = next_ptr(gnt_q);
                end else if (HOLD_EN && hold_cnt_q == HOLD_LAST) begin
                    state_d    = ST_TURN;
                    gnt_d      = 3'b000;
                    hold_cnt_d = 8'd0;
                    turn_cnt_d = 3'd0;
                    rr_ptr_d   = next_ptr(gnt_q);
                    timeout_d  = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end

            ST_TURN: begin
                if (turn_cnt_q == TURN_LAST) begin
                    turn_cnt_d = 3'd0;
                    if (winner != 3'b000) begin
                        state_d    = ST_GRANT;
                        gnt_d      = winner;
                        hold_cnt_d = 8'd0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 3'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
            end
        endcase

        // Registering busy from the next state keeps it aligned with gnt.
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 3'b000;
            busy_q      <= 1'b0;
            sel_data_q  <= 8'h00;
            sel_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            rr_ptr_q    <= 2'd0;
            hold_cnt_q  <= 8'd0;
            turn_cnt_q  <= 3'd0;
        end else begin
            // NOTE: non-blocking assignments make every flop take its value from the pre-edge state.
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            sel_data_q  <= sel_data_d;
            sel_valid_q <= sel_valid_d;
            timeout_q   <= timeout_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            turn_cnt_q  <= turn_cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign sel_data  = sel_data_q;
    assign sel_valid = sel_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_sample_bus_arbiter.sv
// Directed testbench for sample_bus_arbiter with MAX_HOLD=4 and TURN_CYCLES=1.
module tb_sample_bus_arbiter;

    logic       clk;
    logic       rst_n;
    logic [2:0] req;
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [7:0] data_c;
    logic       mode_rr;
    logic [2:0] gnt;
    logic       busy;
    logic [7:0] sel_data;
    logic       sel_valid;
    logic       timeout;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [2:0] rr_order [4];

    sample_bus_arbiter #(
        .MAX_HOLD    (4),
        .TURN_CYCLES (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .data_a    (data_a),
        .data_b    (data_b),
        .data_c    (data_c),
        .mode_rr   (mode_rr),
        .gnt       (gnt),
        .busy      (busy),
        .sel_data  (sel_data),
        .sel_valid (sel_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    initial begin
        rr_order[0] = 3'b001;
        rr_order[1] = 3'b010;
        rr_order[2] = 3'b100;
        rr_order[3] = 3'b001;

        // Reset with all requests high.
        rst_n   = 1'b0;
        req     = 3'b111;
        mode_rr = 1'b0;
        data_a  = 8'hA1;
        data_b  = 8'h5A;
        data_c  = 8'hC3;
        #22;
        check("rst_gnt",       {5'd0, gnt},       8'h00);
        check("rst_busy",      {7'd0, busy},      8'h00);
        check("rst_sel_valid", {7'd0, sel_valid}, 8'h00);
        check("rst_sel_data",  sel_data,          8'h00);
        check("rst_timeout",   {7'd0, timeout},   8'h00);
        rst_n = 1'b1;
        step();
        check("first_gnt_a",  {5'd0, gnt},  8'h01);
        check("first_busy",   {7'd0, busy}, 8'h01);

        // Release A. One turnaround cycle follows, then the arbiter goes idle.
        req = 3'b000;
        step();
        check("a_rel_gnt",       {5'd0, gnt},       8'h00);
        check("a_rel_busy",      {7'd0, busy},      8'h01);
        check("a_rel_sel_valid", {7'd0, sel_valid}, 8'h01);
        check("a_rel_sel_data",  sel_data,          8'hA1);
        check("a_rel_timeout",   {7'd0, timeout},   8'h00);
        step();
        check("idle_busy",      {7'd0, busy},      8'h00);
        check("idle_sel_valid", {7'd0, sel_valid}, 8'h00);

        // Fixed mode with req=110: B wins, then C follows after one zero cycle.
        req = 3'b110;
        step();
        check("fix_gnt_b",      {5'd0, gnt},       8'h02);
        check("fix_b_sv_early", {7'd0, sel_valid}, 8'h00);
        step();
        check("fix_b_hold",     {5'd0, gnt},       8'h02);
        check("fix_b_sel_data", sel_data,          8'h5A);
        check("fix_b_sel_vld",  {7'd0, sel_valid}, 8'h01);
        req = 3'b100;
        step();
        check("fix_b_turn_gnt",  {5'd0, gnt},     8'h00);
        check("fix_b_turn_busy", {7'd0, busy},    8'h01);
        check("fix_b_turn_to",   {7'd0, timeout}, 8'h00);
        step();
        check("fix_gnt_c", {5'd0, gnt}, 8'h04);
        step();
        check("fix_c_sel_data", sel_data, 8'hC3);
        req = 3'b000;
        step();
        step();
        check("fix_c_idle_busy", {7'd0, busy}, 8'h00);

        // RR mode with all requests held. Each tenure lasts 4 cycles and ends with a timeout.
        mode_rr = 1'b1;
        req     = 3'b111;
        step();
        for (int t = 0; t < 4; t++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("rr_t%0d_c%0d_gnt", t, c), {5'd0, gnt},     {5'd0, rr_order[t]});
                check($sformatf("rr_t%0d_c%0d_to", t, c),  {7'd0, timeout}, 8'h00);
                step();
            end
            check($sformatf("rr_t%0d_turn_gnt", t),  {5'd0, gnt},     8'h00);
            check($sformatf("rr_t%0d_turn_to", t),   {7'd0, timeout}, 8'h01);
            check($sformatf("rr_t%0d_turn_busy", t), {7'd0, busy},    8'h01);
            step();
        end
        check("rr_after_gnt_b", {5'd0, gnt}, 8'h02);
        req = 3'b000;
        step();
        step();
        check("rr_idle_busy", {7'd0, busy}, 8'h00);

        // Fixed mode with all requests held. A is regranted after every turnaround.
        mode_rr = 1'b0;
        req     = 3'b111;
        step();
        for (int t = 0; t < 3; t++) begin
            for (int c = 0; c < 4; c++) begin
                check($sformatf("fx_t%0d_c%0d_gnt", t, c), {5'd0, gnt},     8'h01);
                check($sformatf("fx_t%0d_c%0d_to", t, c),  {7'd0, timeout}, 8'h00);
                step();
            end
            check($sformatf("fx_t%0d_turn_gnt", t), {5'd0, gnt},     8'h00);
            check($sformatf("fx_t%0d_turn_to", t),  {7'd0, timeout}, 8'h01);
            step();
        end

        // A releases on the same edge that its hold would expire. This is a normal release, with no timeout.
        check("both_gnt_a_h0", {5'd0, gnt}, 8'h01);
        step();
        step();
        step();
        check("both_gnt_a_h3", {5'd0, gnt}, 8'h01);
        req = 3'b100;
        step();
        check("both_turn_gnt",  {5'd0, gnt},     8'h00);
        check("both_turn_to",   {7'd0, timeout}, 8'h00);
        check("both_turn_busy", {7'd0, busy},    8'h01);
        step();
        check("both_gnt_c", {5'd0, gnt}, 8'h04);
        step();
        check("c_hold_sel_valid", {7'd0, sel_valid}, 8'h01);

        // Reset asserted during C's tenure clears the outputs without waiting for a clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_gnt",       {5'd0, gnt},       8'h00);
        check("mid_rst_busy",      {7'd0, busy},      8'h00);
        check("mid_rst_sel_valid", {7'd0, sel_valid}, 8'h00);
        check("mid_rst_sel_data",  sel_data,          8'h00);

        // After release, RR with all requests starts from A again, and the hold counter starts fresh.
        req     = 3'b111;
        mode_rr = 1'b1;
        #2;
        rst_n = 1'b1;
        step();
        check("post_rst_gnt_a", {5'd0, gnt}, 8'h01);
        step();
        step();
        step();
        check("post_rst_a_h3", {5'd0, gnt}, 8'h01);
        step();
        check("post_rst_to",  {7'd0, timeout}, 8'h01);
        check("post_rst_gnt0", {5'd0, gnt},    8'h00);
        step();
        check("post_rst_gnt_b", {5'd0, gnt}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
